// File: rtl/gpp_apb_regbank.sv
// gpp_apb_regbank: parametrised APB3 slave register bank for the GPP
// test/peripheral space (successor of the fixed 32x32 GPP regfile).
//
// Optional feature macro: GPP_REGBANK_IRQ_EN
//   defined   -> adds irq / irq_ack; a committed write of bit0=1 (lane 0
//                enabled) to reg 0 raises a sticky irq, cleared by irq_ack
//                (a set on the same edge as an ack wins).
//   undefined -> no irq ports, reg 0 is an ordinary RW register.
//
// Ports
//   HCLK, HRESET      clock, synchronous active-high reset
//   PADDR..PSTRB      APB3 request (address, data, direction, select,
//                     enable, byte strobes)
//   PRDATA            read data, zero whenever PREADY is low
//   PREADY, PSLVERR   registered completion / error response
//   gpp_q             RW register contents, reg i at [32*i+:32], RO slots 0
//   gpp_wr_pulse      one-cycle commit strobe per register
//   ro_d              status inputs for the top NUM_RO indices
//   irq, irq_ack      (GPP_REGBANK_IRQ_EN only) sticky interrupt / ack

module gpp_apb_regbank #(
    parameter int          APB_ADDR_WIDTH = 12,
    parameter int          NUM_REGS       = 32,
    parameter int          NUM_RO         = 4,
    parameter int          WAIT_STATES    = 1,
    parameter logic [31:0] RESET_VAL      = 32'h0
) (
    input  logic                                   HCLK,
    input  logic                                   HRESET,
    input  logic [APB_ADDR_WIDTH-1:0]              PADDR,
    input  logic [31:0]                            PWDATA,
    input  logic                                   PWRITE,
    input  logic                                   PSEL,
    input  logic                                   PENABLE,
    input  logic [3:0]                             PSTRB,
    output logic [31:0]                            PRDATA,
    output logic                                   PREADY,
    output logic                                   PSLVERR,
    output logic [NUM_REGS*32-1:0]                 gpp_q,
    output logic [NUM_REGS-1:0]                    gpp_wr_pulse,
`ifdef GPP_REGBANK_IRQ_EN
    output logic                                   irq,
    input  logic                                   irq_ack,
`endif
    input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] ro_d
);

    localparam int IDXW      = $clog2(NUM_REGS);
    localparam int NUM_RW    = NUM_REGS - NUM_RO;
    localparam int WCNT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]                wcnt_q, wcnt_d;
    logic                      ready_q, ready_d;
    logic                      slverr_q, slverr_d;
    logic [31:0]               prdata_q, prdata_d;
    logic [NUM_REGS-1:0]       pulse_q;

    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic                      write_q;
    logic [3:0]                strb_q;

    logic [31:0]               regs_q [NUM_RW];

    logic                      capture;
    logic                      commit;

    // Decode works on the live bus while the setup phase is being
    // accepted (so zero-wait reads can respond immediately), and on the
    // captured request afterwards.
    logic [APB_ADDR_WIDTH-1:0] dec_addr;
    logic                      dec_write;
    logic [IDXW-1:0]           idx;
    logic [31:0]               idx_w;
    logic [APB_ADDR_WIDTH-1:0] hi_bits;
    logic                      err;
    logic [31:0]               rd_data;

    assign dec_addr  = (state_q == IDLE) ? PADDR : addr_q;
    assign dec_write = (state_q == IDLE) ? PWRITE : write_q;
    assign idx       = dec_addr[IDXW+1:2];
    assign idx_w     = 32'(idx);
    assign hi_bits   = dec_addr >> (IDXW + 2);

    assign err = (dec_addr[1:0] != 2'b00)
              || (idx_w >= 32'(NUM_REGS))
              || (|hi_bits)
              || (dec_write && (idx_w >= 32'(NUM_RW)));

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (idx == IDXW'(i)) begin
                rd_data = regs_q[i];
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (idx == IDXW'(NUM_RW + k)) begin
                rd_data = ro_d[32*k +: 32];
            end
        end
    end

    // Response value presented together with PREADY: reads return data,
    // writes and errored transfers return zero.
    logic [31:0] resp_data;
    assign resp_data = (dec_write || err) ? '0 : rd_data;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        prdata_d = '0;
        capture  = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = err;
                        prdata_d = resp_data;
                    end else begin
                        state_d = WAIT;
                        wcnt_d  = 3'(WCNT_INIT);
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (wcnt_q == 3'd0) begin
                    state_d  = RESP;
                    ready_d  = 1'b1;
                    slverr_d = err;
                    prdata_d = resp_data;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                commit  = PSEL && PENABLE && write_q && !slverr_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            prdata_q <= '0;
            pulse_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            ready_q  <= ready_d;
            slverr_q <= slverr_d;
            prdata_q <= prdata_d;
            if (capture) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                write_q <= PWRITE;
                strb_q  <= PSTRB;
            end
            for (int i = 0; i < NUM_RW; i++) begin
                if (commit && idx == IDXW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb_q[b]) begin
                            regs_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
            end
            if (commit) begin
                pulse_q <= {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
            end else begin
                pulse_q <= '0;
            end
        end
    end

`ifdef GPP_REGBANK_IRQ_EN
    logic irq_q;
    logic irq_set;

    assign irq_set = commit && (idx == '0) && wdata_q[0] && strb_q[0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        if (g < NUM_RW) begin : g_rw
            assign gpp_q[32*g +: 32] = regs_q[g];
        end else begin : g_ro
            assign gpp_q[32*g +: 32] = '0;
        end
    end

    assign PRDATA       = prdata_q;
    assign PREADY       = ready_q;
    assign PSLVERR      = slverr_q;
    assign gpp_wr_pulse = pulse_q;

endmodule

// File: tb/tb_gpp_apb_regbank.sv
// tb_gpp_apb_regbank: directed bench for gpp_apb_regbank.
// Instance a uses WAIT_STATES=1, instance b uses WAIT_STATES=0.

module tb_gpp_apb_regbank;

    logic          clk;
    logic          rst;
    logic [11:0]   paddr;
    logic [31:0]   pwdata;
    logic          pwrite;
    logic          psel_a;
    logic          psel_b;
    logic          penable;
    logic [3:0]    pstrb;
    logic [127:0]  ro_d;

    logic [31:0]   prdata_a, prdata_b;
    logic          pready_a, pready_b;
    logic          pslverr_a, pslverr_b;
    logic [1023:0] gpp_q_a, gpp_q_b;
    logic [31:0]   pulse_a, pulse_b;
`ifdef GPP_REGBANK_IRQ_EN
    logic          irq_a, irq_b;
    logic          irq_ack;
`endif

    int checks = 0;
    int errors = 0;

    gpp_apb_regbank #(.WAIT_STATES(1)) u_dut_a (
        .HCLK         (clk),
        .HRESET       (rst),
        .PADDR        (paddr),
        .PWDATA       (pwdata),
        .PWRITE       (pwrite),
        .PSEL         (psel_a),
        .PENABLE      (penable),
        .PSTRB        (pstrb),
        .PRDATA       (prdata_a),
        .PREADY       (pready_a),
        .PSLVERR      (pslverr_a),
        .gpp_q        (gpp_q_a),
        .gpp_wr_pulse (pulse_a),
`ifdef GPP_REGBANK_IRQ_EN
        .irq          (irq_a),
        .irq_ack      (irq_ack),
`endif
        .ro_d         (ro_d)
    );

    gpp_apb_regbank #(.WAIT_STATES(0)) u_dut_b (
        .HCLK         (clk),
        .HRESET       (rst),
        .PADDR        (paddr),
        .PWDATA       (pwdata),
        .PWRITE       (pwrite),
        .PSEL         (psel_b),
        .PENABLE      (penable),
        .PSTRB        (pstrb),
        .PRDATA       (prdata_b),
        .PREADY       (pready_b),
        .PSLVERR      (pslverr_b),
        .gpp_q        (gpp_q_b),
        .gpp_wr_pulse (pulse_b),
`ifdef GPP_REGBANK_IRQ_EN
        .irq          (irq_b),
        .irq_ack      (irq_ack),
`endif
        .ro_d         (ro_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [1023:0] act,
                         input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One APB transfer; PWDATA is scrambled during the access phase so
    // only the setup-phase value may be used by the slave.
    task automatic apb(input bit which, input logic [11:0] a,
                       input logic [31:0] d, input bit w,
                       input logic [3:0] s, output logic [31:0] rd,
                       output logic er, output int nw,
                       output logic [31:0] pls);
        @(posedge clk); #1;
        psel_a  = !which;
        psel_b  = which;
        penable = 1'b0;
        paddr   = a;
        pwdata  = d;
        pwrite  = w;
        pstrb   = s;
        @(posedge clk); #1;
        penable = 1'b1;
        pwdata  = ~d;
        nw = 0;
        while (!(which ? pready_b : pready_a) && nw < 20) begin
            @(posedge clk); #1;
            nw++;
        end
        if (nw >= 20) begin
            errors++;
            $display("FAIL timeout actual=no_pready required=pready");
        end
        rd = which ? prdata_b : prdata_a;
        er = which ? pslverr_b : pslverr_a;
        @(posedge clk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pls = which ? pulse_b : pulse_a;
    endtask

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        bit          w;
        logic [3:0]  s;
        logic [31:0] rd;
        bit          er;
        logic [31:0] pls;
    } vec_t;

    vec_t v[17];

    initial begin
        logic [31:0]   rd;
        logic          er;
        int            nw;
        logic [31:0]   pls;
        logic [1023:0] exp_q;
        bit            bad;

        v[0]  = '{12'h00C, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0};
        v[1]  = '{12'h00C, 32'hDEADBEEF, 1, 4'h5, 32'h0,        0, 32'h8};
        v[2]  = '{12'h00C, 32'h0,        0, 4'h0, 32'h00AD00EF, 0, 32'h0};
        v[3]  = '{12'h00C, 32'h11223344, 1, 4'hA, 32'h0,        0, 32'h8};
        v[4]  = '{12'h00C, 32'h0,        0, 4'h0, 32'h11AD33EF, 0, 32'h0};
        v[5]  = '{12'h00C, 32'hFFFFFFFF, 1, 4'h0, 32'h0,        0, 32'h8};
        v[6]  = '{12'h00C, 32'h0,        0, 4'h0, 32'h11AD33EF, 0, 32'h0};
        v[7]  = '{12'h070, 32'h0,        0, 4'h0, 32'h12345678, 0, 32'h0};
        v[8]  = '{12'h070, 32'hFFFFFFFF, 1, 4'hF, 32'h0,        1, 32'h0};
        v[9]  = '{12'h070, 32'h0,        0, 4'h0, 32'h12345678, 0, 32'h0};
        v[10] = '{12'h100, 32'h0,        0, 4'h0, 32'h0,        1, 32'h0};
        v[11] = '{12'h006, 32'h55AA55AA, 1, 4'hF, 32'h0,        1, 32'h0};
        v[12] = '{12'h06C, 32'h0000ABCD, 1, 4'hF, 32'h0,        0,
                  32'h0800_0000};
        v[13] = '{12'h06C, 32'h0,        0, 4'h0, 32'h0000ABCD, 0, 32'h0};
        v[14] = '{12'h07C, 32'h0,        0, 4'h0, 32'hA5A50003, 0, 32'h0};
        v[15] = '{12'h080, 32'h77777777, 1, 4'hF, 32'h0,        1, 32'h0};
        v[16] = '{12'h000, 32'h0,        0, 4'h0, 32'h0,        0, 32'h0};

        rst     = 1'b1;
        paddr   = '0;
        pwdata  = '0;
        pwrite  = 1'b0;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        pstrb   = '0;
        ro_d    = {32'hA5A50003, 32'h0BADF00D, 32'hFFFF0000, 32'h12345678};
`ifdef GPP_REGBANK_IRQ_EN
        irq_ack = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_q("rst_gpp_q", gpp_q_a, '0);
        chk("rst_pready", 32'(pready_a), 32'h0);
        chk("rst_pslverr", 32'(pslverr_a), 32'h0);
        chk("rst_pulse", pulse_a, 32'h0);
        chk("rst_prdata", prdata_a, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apb(1'b0, v[i].a, v[i].d, v[i].w, v[i].s, rd, er, nw, pls);
            chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("v%0d_err", i), 32'(er), 32'(v[i].er));
            chk($sformatf("v%0d_pulse", i), pls, v[i].pls);
            chk($sformatf("v%0d_wait", i), 32'(nw), 32'd1);
        end

        exp_q = '0;
        exp_q[3*32 +: 32]  = 32'h11AD33EF;
        exp_q[27*32 +: 32] = 32'h0000ABCD;
        chk_q("gpp_q_after_vecs", gpp_q_a, exp_q);

        // Back-to-back write then read, zero wait states.
        @(posedge clk); #1;
        psel_b  = 1'b1;
        penable = 1'b0;
        paddr   = 12'h000;
        pwdata  = 32'hCAFEF00D;
        pwrite  = 1'b1;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("b2b_wr_ready", 32'(pready_b), 32'h1);
        chk("b2b_wr_err", 32'(pslverr_b), 32'h0);
        @(posedge clk); #1;
        penable = 1'b0;
        pwrite  = 1'b0;
        pwdata  = 32'h0;
        chk("b2b_gap_ready", 32'(pready_b), 32'h0);
        chk("b2b_pulse", pulse_b, 32'h1);
        @(posedge clk); #1;
        penable = 1'b1;
        chk("b2b_rd_ready", 32'(pready_b), 32'h1);
        chk("b2b_rd_data", prdata_b, 32'hCAFEF00D);
        @(posedge clk); #1;
        psel_b  = 1'b0;
        penable = 1'b0;
        chk("b2b_end_ready", 32'(pready_b), 32'h0);
        chk("b2b_end_prdata", prdata_b, 32'h0);

        // PSEL dropped during the wait state: transfer abandoned.
        @(posedge clk); #1;
        psel_a  = 1'b1;
        penable = 1'b0;
        paddr   = 12'h004;
        pwdata  = 32'h00000077;
        pwrite  = 1'b1;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        psel_a = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (pready_a || pulse_a != 0) bad = 1'b1;
        end
        chk("abort_quiet", 32'(bad), 32'h0);
        chk("abort_reg1", gpp_q_a[32 +: 32], 32'h0);

`ifdef GPP_REGBANK_IRQ_EN
        chk("irq_idle", 32'(irq_a), 32'h0);
        irq_ack = 1'b1;
        apb(1'b0, 12'h000, 32'h00000001, 1'b1, 4'h1, rd, er, nw, pls);
        chk("irq_set_wins", 32'(irq_a), 32'h1);
        @(posedge clk); #1;
        chk("irq_acked", 32'(irq_a), 32'h0);
        irq_ack = 1'b0;
`endif

        // Reset during the wait state of a write.
        @(posedge clk); #1;
        psel_a  = 1'b1;
        penable = 1'b0;
        paddr   = 12'h014;
        pwdata  = 32'h00000055;
        pwrite  = 1'b1;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        chk("rstwait_ready", 32'(pready_a), 32'h0);
        rst     = 1'b0;
        psel_a  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        chk("rstwait_ready2", 32'(pready_a), 32'h0);
        chk("rstwait_pulse", pulse_a, 32'h0);
        chk("rstwait_reg5", gpp_q_a[5*32 +: 32], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
